mem_access_unit: RTL

- Load/store engine for the tiny16 core; the memory-side counterpart of the register file's memory port.
- Accepts one load/store request at a time from the control unit.
- Moves a 16-bit word between a register and byte-wide external memory in two bus beats.
- Loads: delivers the assembled word to the register file's load port. Stores: takes store data from the register file's store port.

---
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit.sv | 84 ++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request, register-file and byte-bus signals of the load/store unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [3:0]  req_reg;
    logic [15:0] req_addr;
    logic [3:0]  mem_index;
    logic [15:0] mem_store_data;
    logic [15:0] mem_load_data;
    logic        mem_load_en;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;
    logic        done;
    logic        err;
    modport master (
        input  req_valid, req_store, req_reg, req_addr, mem_store_data, bus_rdata, bus_ack,
        output req_ready, mem_index, mem_load_data, mem_load_en, bus_req, bus_we, bus_addr,
               bus_wdata, done, err
    );
    modport slave (
        output req_valid, req_store, req_reg, req_addr, mem_store_data, bus_rdata, bus_ack,
        input  req_ready, mem_index, mem_load_data, mem_load_en, bus_req, bus_we, bus_addr,
               bus_wdata, done, err
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: moves a 16-bit register word to/from byte-wide memory in two bus beats
module mem_access_unit #(
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic clk,
    input logic rst,
    mem_access_unit_if.master io
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;
    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [3:0]  reg_q, reg_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        beat, lane_lo, fin, timed_out;
    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        reg_d     = reg_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        beat      = state_q == BEAT0 || state_q == BEAT1;
        lane_lo   = (state_q == BEAT0) != BIG_ENDIAN;
        fin       = state_q == FIN;
        timed_out = TIMEOUT != 0 && cnt_q == 8'(TIMEOUT - 1);
        case (state_q)
            IDLE: if (io.req_valid && !rst) begin
                store_d = io.req_store;
                reg_d   = io.req_reg;
                addr_d  = io.req_addr;
                data_d  = io.req_store && io.req_reg != 4'd0 ? io.mem_store_data : 16'h0000;
                cnt_d   = 8'd0;
                err_d   = 1'b0;
                state_d = BEAT0;
            end
            BEAT0, BEAT1: if (io.bus_ack) begin
                data_d  = store_q ? data_q :
                          lane_lo ? {data_q[15:8], io.bus_rdata} : {io.bus_rdata, data_q[7:0]};
                cnt_d   = 8'd0;
                state_d = state_q == BEAT0 ? BEAT1 : FIN;
            end else if (timed_out) begin
                err_d   = 1'b1;
                state_d = FIN;
            end else begin
                cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            reg_q   <= 4'd0;
            addr_q  <= 16'h0000;
            data_q  <= 16'h0000;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            reg_q   <= reg_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    assign io.req_ready     = state_q == IDLE && !rst;
    assign io.mem_index     = state_q == IDLE ? io.req_reg : reg_q;
    assign io.bus_req       = beat;
    assign io.bus_we        = beat && store_q;
    assign io.bus_addr      = state_q == BEAT0 ? addr_q : state_q == BEAT1 ? addr_q + 16'd1 : 16'h0000;
    assign io.bus_wdata     = beat && store_q ? (lane_lo ? data_q[7:0] : data_q[15:8]) : 8'h00;
    assign io.done          = fin;
    assign io.err           = fin && err_q;
    assign io.mem_load_en   = fin && !store_q && !err_q && reg_q != 4'd0;
    assign io.mem_load_data = io.mem_load_en ? data_q : 16'h0000;
endmodule
